// File: rtl/pipeline_pkg.sv
// Shared encodings, FSM state type and in-flight tracker entry used by the
// hazard controller and its tracker.
package pipeline_pkg;

    localparam logic [5:0] SEL_REGFILE = 6'b000001;
    localparam logic [5:0] SEL_EX      = 6'b000010;
    localparam logic [5:0] SEL_EXMEM   = 6'b000100;
    localparam logic [5:0] SEL_MEMWB   = 6'b001000;
    localparam logic [5:0] SEL_IMM     = 6'b100000;

    localparam int TRK_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } trk_entry_t;

endpackage

// File: rtl/inflight_tracker.sv
// Three-entry EX/MEM/WB destination tracker with youngest-first operand
// matching; index 0 is EX, 1 is MEM, 2 is WB.
module inflight_tracker
    import pipeline_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       freeze_i,
    input  trk_entry_t ex_new_i,
    input  logic [4:0] src_hi_i,
    input  logic [4:0] src_lo_i,
    output logic [4:0] sel_hi_o,
    output logic [4:0] sel_lo_o,
    output logic       ld_hit_hi_o,
    output logic       ld_hit_lo_o
);

    trk_entry_t [TRK_DEPTH-1:0] trk_q;

    // Returns {load_hit, one-hot select}; a load still in EX or MEM has no
    // data yet, so it blocks forwarding and flags a load-use hit instead.
    function automatic logic [5:0] resolve(input trk_entry_t [TRK_DEPTH-1:0] trk,
                                           input logic [4:0] src);
        logic [4:0] sel;
        logic       ld_hit;
        sel    = SEL_REGFILE[4:0];
        ld_hit = 1'b0;
        for (int k = TRK_DEPTH - 1; k >= 0; k--) begin
            if (trk[k].valid && (trk[k].dest == src)) begin
                if (trk[k].is_load && (k != TRK_DEPTH - 1)) begin
                    sel    = SEL_REGFILE[4:0];
                    ld_hit = 1'b1;
                end else begin
                    sel = SEL_EX[4:0] << k;
                end
            end
        end
        return {ld_hit, sel};
    endfunction

    always_comb begin
        {ld_hit_hi_o, sel_hi_o} = resolve(trk_q, src_hi_i);
        {ld_hit_lo_o, sel_lo_o} = resolve(trk_q, src_lo_i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < TRK_DEPTH; k++) begin
                trk_q[k].valid <= 1'b0;
            end
        end else if (!freeze_i) begin
            trk_q <= {trk_q[TRK_DEPTH-2:0], ex_new_i};
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Forwarding-select, load-use stall and memory-wait freeze control for a
// five-stage pipeline; the FSM lives here, operand matching in the tracker.
module pipeline_hazard_controller
    import pipeline_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [4:0] dec_addr_low,
    input  logic [4:0] dec_addr_high,
    input  logic       dec_writes,
    input  logic       dec_is_load,
    input  logic       dec_use_imm,
    input  logic       mem_ready,
    input  logic       flush,
    output logic [4:0] alu_top_sel,
    output logic [5:0] alu_bot_sel,
    output logic       stall_req,
    output logic       bubble_insert,
    output logic       freeze
);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    state_e     cur_state;
    logic       flush_pend_q, flush_pend_d;
    logic       flush_eff;
    logic       hazard;
    logic [4:0] sel_hi, sel_lo;
    logic       ld_hit_hi, ld_hit_lo;
    trk_entry_t ex_new;

    // A flush seen while memory held the pipeline is replayed on the exit cycle
    assign flush_eff = flush | flush_pend_q;
    assign hazard    = dec_valid & (ld_hit_hi | (ld_hit_lo & ~dec_use_imm));

    inflight_tracker u_tracker (
        .clock       (clock),
        .reset       (reset),
        .freeze_i    (freeze),
        .ex_new_i    (ex_new),
        .src_hi_i    (dec_addr_high),
        .src_lo_i    (dec_addr_low),
        .sel_hi_o    (sel_hi),
        .sel_lo_o    (sel_lo),
        .ld_hit_hi_o (ld_hit_hi),
        .ld_hit_lo_o (ld_hit_lo)
    );

    always_comb begin
        freeze        = 1'b0;
        stall_req     = 1'b0;
        bubble_insert = 1'b0;
        if (!reset) begin
            if (!mem_ready) begin
                freeze    = 1'b1;
                stall_req = 1'b1;
            end else if (!flush_eff) begin
                stall_req     = hazard;
                bubble_insert = hazard;
            end
        end
    end

    always_comb begin
        ex_new.valid   = dec_valid & dec_writes & ~stall_req & ~flush_eff;
        ex_new.dest    = dec_addr_low;
        ex_new.is_load = dec_is_load;
    end

    always_comb begin
        alu_top_sel = SEL_REGFILE[4:0];
        alu_bot_sel = SEL_REGFILE;
        if (dec_valid) begin
            alu_top_sel = sel_hi;
            alu_bot_sel = dec_use_imm ? SEL_IMM : {1'b0, sel_lo};
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        flush_pend_d = 1'b0;
        cur_state    = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
        if (!mem_ready) begin
            state_d      = ST_MEM_WAIT;
            flush_pend_d = flush_pend_q | flush;
            if (state_q != ST_MEM_WAIT) begin
                ret_d = state_q;
            end
        end else if (flush_eff) begin
            state_d = ST_RUN;
        end else begin
            case (cur_state)
                ST_RUN:        state_d = hazard ? ST_LOAD_STALL : ST_RUN;
                ST_LOAD_STALL: state_d = hazard ? ST_LOAD_STALL : ST_RUN;
                default:       state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            ret_q        <= ST_RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller: the driver queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_pipeline_hazard_controller;

    localparam logic [4:0] RT = 5'b00001;
    localparam logic [5:0] RB = 6'b000001;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_addr_low = '0;
    logic [4:0] dec_addr_high = '0;
    logic       dec_writes = 1'b0;
    logic       dec_is_load = 1'b0;
    logic       dec_use_imm = 1'b0;
    logic       mem_ready = 1'b1;
    logic       flush = 1'b0;
    logic [4:0] alu_top_sel;
    logic [5:0] alu_bot_sel;
    logic       stall_req;
    logic       bubble_insert;
    logic       freeze;

    typedef struct packed {
        logic       chk;
        logic [4:0] top;
        logic [5:0] bot;
        logic       st;
        logic       bb;
        logic       fz;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    pipeline_hazard_controller dut (
        .clock         (clock),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_addr_low  (dec_addr_low),
        .dec_addr_high (dec_addr_high),
        .dec_writes    (dec_writes),
        .dec_is_load   (dec_is_load),
        .dec_use_imm   (dec_use_imm),
        .mem_ready     (mem_ready),
        .flush         (flush),
        .alu_top_sel   (alu_top_sel),
        .alu_bot_sel   (alu_bot_sel),
        .stall_req     (stall_req),
        .bubble_insert (bubble_insert),
        .freeze        (freeze)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle presents outputs; compare against the oldest expectation
    exp_t  mon_e;
    string mon_nm;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            if (mon_e.chk) begin
                checks++;
                if ({alu_top_sel, alu_bot_sel, stall_req, bubble_insert, freeze} !==
                    {mon_e.top, mon_e.bot, mon_e.st, mon_e.bb, mon_e.fz}) begin
                    failures++;
                    $display("FAIL %s: got top=%b bot=%b stall=%b bubble=%b freeze=%b, want top=%b bot=%b stall=%b bubble=%b freeze=%b",
                             mon_nm, alu_top_sel, alu_bot_sel, stall_req, bubble_insert, freeze,
                             mon_e.top, mon_e.bot, mon_e.st, mon_e.bb, mon_e.fz);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic rs, input logic mr, input logic fl,
                       input logic v, input logic [4:0] lo, input logic [4:0] hi,
                       input logic wr, input logic ld, input logic imm, input logic chk,
                       input logic [4:0] et, input logic [5:0] eb,
                       input logic es, input logic ebb, input logic ef);
        exp_t e;
        @(posedge clock);
        #1;
        reset         = rs;
        mem_ready     = mr;
        flush         = fl;
        dec_valid     = v;
        dec_addr_low  = lo;
        dec_addr_high = hi;
        dec_writes    = wr;
        dec_is_load   = ld;
        dec_use_imm   = imm;
        e = '{chk: chk, top: et, bot: eb, st: es, bb: ebb, fz: ef};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic nop(input string nm);
        cyc(nm, 0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 1, RT, RB, 0, 0, 0);
    endtask

    task automatic wr_r(input string nm, input logic [4:0] rd, input logic ld);
        cyc(nm, 0, 1, 0, 1, rd, 5'd0, 1, ld, 0, 1, RT, RB, 0, 0, 0);
    endtask

    initial begin
        cyc("rst0", 1, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, RT, RB, 0, 0, 0);
        cyc("rst1", 1, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, RT, RB, 0, 0, 0);
        nop("reset_vals");

        // ALU write r3, forward from EX
        wr_r("a_wr_r3", 5'd3, 0);
        cyc("fwd_ex", 0, 1, 0, 1, 5'd7, 5'd3, 0, 0, 0, 1, 5'b00010, RB, 0, 0, 0);
        nop("a_nop1"); nop("a_nop2");

        // r3 two cycles back -> EX/MEM
        wr_r("b_wr_r3", 5'd3, 0);
        nop("b_nop");
        cyc("fwd_exmem", 0, 1, 0, 1, 5'd8, 5'd3, 0, 0, 0, 1, 5'b00100, RB, 0, 0, 0);
        nop("b_nop2");

        // r3 three cycles back -> MEM/WB
        wr_r("c_wr_r3", 5'd3, 0);
        nop("c_nop1"); nop("c_nop2");
        cyc("fwd_memwb", 0, 1, 0, 1, 5'd8, 5'd3, 0, 0, 0, 1, 5'b01000, RB, 0, 0, 0);

        // r3 in both EX and MEM -> youngest (EX)
        wr_r("d_wr_r3", 5'd3, 0);
        cyc("d_wr_r3_again", 0, 1, 0, 1, 5'd3, 5'd0, 1, 0, 0, 1, RT, 6'b000010, 0, 0, 0);
        cyc("fwd_youngest", 0, 1, 0, 1, 5'd9, 5'd3, 0, 0, 0, 1, 5'b00010, RB, 0, 0, 0);
        nop("d_nop1"); nop("d_nop2");

        // Same address on both operands, immediate override, dec_valid=0
        wr_r("e_wr_r4", 5'd4, 0);
        cyc("same_addr", 0, 1, 0, 1, 5'd4, 5'd4, 0, 0, 0, 1, 5'b00010, 6'b000010, 0, 0, 0);
        cyc("imm_sel", 0, 1, 0, 1, 5'd4, 5'd4, 0, 0, 1, 1, 5'b00100, 6'b100000, 0, 0, 0);
        cyc("invalid_dec", 0, 1, 0, 0, 5'd4, 5'd4, 0, 0, 0, 1, RT, RB, 0, 0, 0);

        // Load r5 then use r5 as low: two stall cycles then MEM/WB forward
        wr_r("f_ld_r5", 5'd5, 1);
        cyc("ld_stall1", 0, 1, 0, 1, 5'd5, 5'd6, 1, 0, 0, 1, RT, RB, 1, 1, 0);
        cyc("ld_stall2", 0, 1, 0, 1, 5'd5, 5'd6, 1, 0, 0, 1, RT, RB, 1, 1, 0);
        cyc("ld_fwd", 0, 1, 0, 1, 5'd5, 5'd6, 1, 0, 0, 1, RT, 6'b001000, 0, 0, 0);
        nop("f_nop1"); nop("f_nop2"); nop("f_nop3");

        // mem_ready low for 3 cycles during a load stall
        wr_r("g_ld_r5", 5'd5, 1);
        cyc("g_stall", 0, 1, 0, 1, 5'd5, 5'd6, 0, 0, 0, 1, RT, RB, 1, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc("memwait_freeze", 0, 0, 0, 1, 5'd5, 5'd6, 0, 0, 0, 1, RT, RB, 1, 0, 1);
        cyc("stall_resume", 0, 1, 0, 1, 5'd5, 5'd6, 0, 0, 0, 1, RT, RB, 1, 1, 0);
        cyc("g_fwd", 0, 1, 0, 1, 5'd5, 5'd6, 0, 0, 0, 1, RT, 6'b001000, 0, 0, 0);

        // Flush during LOAD_STALL
        wr_r("h_ld_r5", 5'd5, 1);
        cyc("h_stall", 0, 1, 0, 1, 5'd5, 5'd6, 0, 0, 0, 1, RT, RB, 1, 1, 0);
        cyc("flush_stall", 0, 1, 1, 1, 5'd5, 5'd7, 1, 0, 0, 1, RT, RB, 0, 0, 0);
        cyc("flush_ex_inv", 0, 1, 0, 1, 5'd9, 5'd5, 0, 0, 0, 1, 5'b01000, RB, 0, 0, 0);

        // Reset mid-stall, with mem_ready low and flush high
        wr_r("i_ld_r5", 5'd5, 1);
        cyc("i_stall", 0, 1, 0, 1, 5'd5, 5'd6, 0, 0, 0, 1, RT, RB, 1, 1, 0);
        cyc("i_reset", 1, 0, 1, 1, 5'd5, 5'd6, 0, 0, 0, 0, RT, RB, 0, 0, 0);
        cyc("post_reset", 0, 1, 0, 1, 5'd5, 5'd5, 0, 0, 0, 1, RT, RB, 0, 0, 0);

        // Flush while frozen is held and applied on the exit cycle
        wr_r("j_wr_r8", 5'd8, 0);
        cyc("frz_flush", 0, 0, 1, 1, 5'd9, 5'd8, 1, 0, 0, 1, 5'b00010, RB, 1, 0, 1);
        cyc("pend_flush", 0, 1, 0, 1, 5'd9, 5'd8, 1, 0, 0, 1, 5'b00010, RB, 0, 0, 0);
        cyc("pend_ex_inv", 0, 1, 0, 1, 5'd10, 5'd9, 0, 0, 0, 1, RT, RB, 0, 0, 0);

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
